// File: rtl/als_spi_responder_if.sv
// als_spi_responder_if
//   Bundle of the SPI pins and the sample/receive side-band signals of the
//   ambient-light-sensor ADC emulator.
//   Signal names keep the responder's point of view (_i = into responder).
//   Modports:
//     master : drives sclk/cs/mosi and the sample load strobe, observes results
//     slave  : the responder itself
//   Parameter FRAME_BITS sets the width of the captured MOSI word.
interface als_spi_responder_if #(
  parameter int FRAME_BITS = 16
);
  logic                  sclk_i;
  logic                  cs_i;
  logic                  mosi_i;
  logic                  miso_o;
  logic [7:0]            sample_i;
  logic                  sample_wr_i;
  logic [FRAME_BITS-1:0] rx_data_o;
  logic                  frame_done_o;
  logic                  busy_o;
  logic                  stale_o;

  modport master (
    output sclk_i, cs_i, mosi_i, sample_i, sample_wr_i,
    input  miso_o, rx_data_o, frame_done_o, busy_o, stale_o
  );

  modport slave (
    input  sclk_i, cs_i, mosi_i, sample_i, sample_wr_i,
    output miso_o, rx_data_o, frame_done_o, busy_o, stale_o
  );
endinterface

// File: rtl/als_spi_responder.sv
// als_spi_responder
//   SPI responder (CPOL=0, CPHA=0) emulating the ambient-light sensor ADC.
//   One FRAME_BITS-bit read frame per chip-select assertion carries an 8-bit
//   light sample preceded by LEAD_ZEROS zero bits and followed by zeros.
//   The MOSI bits shifted in during the frame are captured MSB first.
//
//   Ports:
//     clck_i  system clock
//     rst_i   asynchronous active-low reset
//     bus     als_spi_responder_if.slave:
//               sclk_i/cs_i/mosi_i  SPI pins from master (async to clck_i)
//               miso_o              SPI data to master
//               sample_i/sample_wr_i next sample and its one-cycle load strobe
//               rx_data_o           last complete MOSI frame
//               frame_done_o        one-cycle pulse when a full frame ends
//               busy_o              frame in progress
//               stale_o             frame in flight repeats an already-sent sample
//
//   Optional build macro ALS_RESP_LFSR_EN: the sample comes from an internal
//   8-bit Galois LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) that advances once per
//   completed frame; sample_i/sample_wr_i are ignored and stale_o stays 0.
module als_spi_responder #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_ZEROS = 3
) (
  input logic               clck_i,
  input logic               rst_i,
  als_spi_responder_if.slave bus
);

  localparam int TRAIL_BITS = FRAME_BITS - LEAD_ZEROS - 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

`ifdef ALS_RESP_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Synchronizers and edge strobes
  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_prev_q;
  logic       cs_prev_q;
  logic       mosi_dly_q;
  logic       sclk_rise_q;
  logic       sclk_fall_q;
  logic       cs_rise_q;
  logic       cs_fall_q;

  // Frame state
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;
  logic                  stale_q, stale_d;
  logic                  miso_q, miso_d;
  logic [7:0]            hold_q, hold_d;
  logic                  fresh_q, fresh_d;

  logic [7:0]            sample_src_s;
  logic [FRAME_BITS-1:0] frame_word_s;
  logic                  sample_wr_s;

  // Two-flop synchronizers plus registered edge strobes (3 cycles pin->strobe).
  // The cs chain resets low so a chip select already asserted at reset
  // release produces no fall strobe; a high cs only yields a harmless rise.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      mosi_dly_q  <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], bus.sclk_i};
      cs_sync_q   <= {cs_sync_q[0], bus.cs_i};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi_i};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      // MOSI is delayed one more stage so it lines up with the registered strobe
      mosi_dly_q  <= mosi_sync_q[1];
      sclk_rise_q <= sclk_sync_q[1] & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_sync_q[1] & sclk_prev_q;
      cs_rise_q   <= cs_sync_q[1] & ~cs_prev_q;
      cs_fall_q   <= ~cs_sync_q[1] & cs_prev_q;
    end
  end

`ifdef ALS_RESP_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Galois LFSR step, once per completed frame.
  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_done_d) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sample_src_s = lfsr_q;
  assign sample_wr_s  = 1'b0;
`else
  assign sample_src_s = hold_q;
  assign sample_wr_s  = bus.sample_wr_i;
`endif

  // Frame image: LEAD_ZEROS zeros, the sample, then trailing zeros.
  assign frame_word_s = FRAME_BITS'(sample_src_s) << TRAIL_BITS;

  // Next-state and output logic of the frame FSM and holding register.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    rx_data_d    = rx_data_q;
    frame_done_d = 1'b0;
    stale_d      = stale_q;
    fresh_d      = fresh_q;
    hold_d       = hold_q;
    miso_d       = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_q) begin
          // Loads the current hold_q; a same-cycle write lands afterwards
          shift_d    = frame_word_s;
          rx_shift_d = {FRAME_BITS{1'b0}};
          stale_d    = ~fresh_q;
          fresh_d    = 1'b0;
          bit_cnt_d  = {CNT_W{1'b0}};
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_q) begin
          // Aborted frame: no completion, rx_data kept, sample stays consumed
          stale_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (sclk_rise_q) begin
            rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_dly_q};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end else begin
            rx_shift_d = rx_shift_q;
            bit_cnt_d  = bit_cnt_q;
          end
          if (sclk_fall_q) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          end else begin
            shift_d = shift_q;
          end
          if (bit_cnt_d == CNT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_HOLD: begin
        if (cs_rise_q) begin
          rx_data_d    = rx_shift_q;
          frame_done_d = 1'b1;
          stale_d      = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sample writes are accepted in any state and always mark the sample fresh
    if (sample_wr_s) begin
      hold_d  = bus.sample_i;
      fresh_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    if (LFSR_EN) begin
      stale_d = 1'b0;
    end else begin
      stale_d = stale_d;
    end

    // Outputs registered from next-state values: MISO follows the strobe by one cycle
    if (state_d == ST_SHIFT) begin
      miso_d = shift_d[FRAME_BITS-1];
    end else begin
      miso_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Frame FSM state and output registers.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      shift_q      <= {FRAME_BITS{1'b0}};
      rx_shift_q   <= {FRAME_BITS{1'b0}};
      bit_cnt_q    <= {CNT_W{1'b0}};
      rx_data_q    <= {FRAME_BITS{1'b0}};
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      stale_q      <= 1'b0;
      miso_q       <= 1'b0;
      hold_q       <= 8'h00;
      fresh_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_data_q    <= rx_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      stale_q      <= stale_d;
      miso_q       <= miso_d;
      hold_q       <= hold_d;
      fresh_q      <= fresh_d;
    end
  end

  assign bus.miso_o       = miso_q;
  assign bus.rx_data_o    = rx_data_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.busy_o       = busy_q;
  assign bus.stale_o      = stale_q;

endmodule

// File: tb/tb_als_spi_responder.sv
// tb_als_spi_responder
//   Drives SPI frames as a CPOL=0/CPHA=0 master and checks the responder
//   against a behavioural model of the sample holding register and the frame
//   contents. Expected frames are queued when a full frame is issued; a
//   monitor compares MISO bits, stale flag and rx_data at each frame_done.
module tb_als_spi_responder;

  localparam int HALF = 8;  // SCLK half period in clck cycles

  typedef struct {
    logic [15:0] miso;
    logic [15:0] rx;
    logic        stale;
  } exp_t;

  logic clck;
  logic rst;

  als_spi_responder_if bus ();

  als_spi_responder dut (
    .clck_i (clck),
    .rst_i  (rst),
    .bus    (bus)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Behavioural model of the sample source
  logic [7:0]  m_hold;
  bit          m_fresh;
  logic [15:0] m_last_rx;

  logic [15:0] miso_word;
  logic        mon_stale;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // MISO as seen by the master on each rising SCLK
  initial begin
    miso_word = 16'h0000;
    forever begin
      @(posedge bus.sclk_i);
      miso_word = {miso_word[14:0], bus.miso_o};
    end
  end

  // Scoreboard monitor
  initial begin
    bit   busy_prev;
    bit   fd_prev;
    exp_t e;
    busy_prev = 1'b0;
    fd_prev   = 1'b0;
    mon_stale = 1'b0;
    forever begin
      @(negedge clck);
      if (!rst) begin
        busy_prev = 1'b0;
        fd_prev   = 1'b0;
      end else begin
        if (bus.busy_o && !busy_prev) begin
          mon_stale = bus.stale_o;
          miso_word = 16'h0000;
        end
        if (bus.frame_done_o) begin
          if (fd_prev) begin
            check("frame_done_width", 32'd2, 32'd1);
          end else if (exp_q.size() == 0) begin
            check("unexpected_frame_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("miso_word", {16'h0, miso_word}, {16'h0, e.miso});
            check("rx_data", {16'h0, bus.rx_data_o}, {16'h0, e.rx});
            check("stale", {31'h0, mon_stale}, {31'h0, e.stale});
          end
        end
        busy_prev = bus.busy_o;
        fd_prev   = bus.frame_done_o;
      end
    end
  end

  task automatic write_sample(input logic [7:0] v);
    @(posedge clck); #1;
    bus.sample_i    = v;
    bus.sample_wr_i = 1'b1;
    @(posedge clck); #1;
    bus.sample_wr_i = 1'b0;
    m_hold  = v;
    m_fresh = 1'b1;
  endtask

  // One frame of n_sclk clocks; optionally a sample write in the cs-fall strobe cycle
  task automatic do_frame(input int n_sclk, input logic [15:0] mosi_w,
                          input bit wr_in_strobe, input logic [7:0] wr_val);
    exp_t e;
    int   cnt;
    e.miso  = {5'b0, m_hold, 3'b0} << 2;
    e.miso  = 16'(m_hold) * 16'd32;
    e.stale = !m_fresh;
    e.rx    = mosi_w;
    m_fresh = 1'b0;
    @(posedge clck); #1;
    bus.cs_i = 1'b0;
    if (wr_in_strobe) begin
      repeat (3) @(posedge clck);
      #1;
      bus.sample_i    = wr_val;
      bus.sample_wr_i = 1'b1;
      @(posedge clck); #1;
      bus.sample_wr_i = 1'b0;
      m_hold  = wr_val;
      m_fresh = 1'b1;
      repeat (4) @(posedge clck);
      #1;
    end else begin
      repeat (HALF) @(posedge clck);
      #1;
    end
    for (int i = 0; i < n_sclk; i++) begin
      bus.mosi_i = mosi_w[15-i];
      repeat (HALF) @(posedge clck);
      #1 bus.sclk_i = 1'b1;
      repeat (HALF) @(posedge clck);
      #1 bus.sclk_i = 1'b0;
    end
    repeat (HALF) @(posedge clck);
    #1;
    if (n_sclk == 16) begin
      exp_q.push_back(e);
      m_last_rx = mosi_w;
    end
    bus.cs_i = 1'b1;
    if (n_sclk == 16) begin
      cnt = 0;
      while (!bus.frame_done_o && cnt < 20) begin
        @(posedge clck); #1;
        cnt++;
      end
      check("frame_done_latency", cnt, 32'd4);
    end else begin
      repeat (10) @(posedge clck);
      #1;
      check("abort_rx_hold", {16'h0, bus.rx_data_o}, {16'h0, m_last_rx});
      check("abort_busy", {31'h0, bus.busy_o}, 32'd0);
    end
    repeat (4) @(posedge clck);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {31'h0, bus.miso_o}, 32'd0);
    check({tag, "_rx_data"}, {16'h0, bus.rx_data_o}, 32'd0);
    check({tag, "_frame_done"}, {31'h0, bus.frame_done_o}, 32'd0);
    check({tag, "_busy"}, {31'h0, bus.busy_o}, 32'd0);
    check({tag, "_stale"}, {31'h0, bus.stale_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst             = 1'b0;
    bus.sclk_i      = 1'b0;
    bus.cs_i        = 1'b1;
    bus.mosi_i      = 1'b0;
    bus.sample_i    = 8'h00;
    bus.sample_wr_i = 1'b0;
    m_hold    = 8'h00;
    m_fresh   = 1'b0;
    m_last_rx = 16'h0000;

    repeat (4) @(posedge clck);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (4) @(posedge clck);

    // Basic read and MOSI capture
    write_sample(8'hB7);
    do_frame(16, 16'hC3A5, 1'b0, 8'h00);
    // Repeat without a new sample -> stale
    do_frame(16, 16'h5A0F, 1'b0, 8'h00);
    // Abort after 7 clocks, then a full frame
    write_sample(8'h5A);
    do_frame(7, 16'hFFFF, 1'b0, 8'h00);
    do_frame(16, 16'h1234, 1'b0, 8'h00);
    // Sample written in the cs-fall strobe cycle
    write_sample(8'h11);
    do_frame(16, 16'hA55A, 1'b1, 8'h3C);
    do_frame(16, 16'h0F0F, 1'b0, 8'h00);

    // Reset pulsed during SCLK 9 with cs held low through release
    @(posedge clck); #1;
    bus.cs_i = 1'b0;
    repeat (HALF) @(posedge clck);
    for (int i = 0; i < 9; i++) begin
      #1 bus.mosi_i = 1'b1;
      repeat (HALF) @(posedge clck);
      #1 bus.sclk_i = 1'b1;
      if (i < 8) begin
        repeat (HALF) @(posedge clck);
        #1 bus.sclk_i = 1'b0;
      end
    end
    repeat (2) @(posedge clck);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    bus.sclk_i = 1'b0;
    m_hold    = 8'h00;
    m_fresh   = 1'b0;
    m_last_rx = 16'h0000;
    repeat (3) @(posedge clck);
    #1 rst = 1'b1;
    repeat (12) @(posedge clck);
    #1;
    check("cs_low_at_release_busy", {31'h0, bus.busy_o}, 32'd0);
    bus.cs_i = 1'b1;
    repeat (10) @(posedge clck);
    do_frame(16, 16'h8001, 1'b0, 8'h00);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        write_sample(8'($urandom_range(0, 255)));
      end
      do_frame(16, 16'($urandom), 1'b0, 8'h00);
    end

    repeat (10) @(posedge clck);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/als_spi_responder.md
# als_spi_responder

SPI responder that emulates the ambient-light sensor's ADC at the far end of the sensor SPI bus. It is the counterpart of the team's SPI master interface, used on-board as a loopback target and in benches in place of the real sensor. It serves one 16-bit read frame per chip-select assertion, carrying an 8-bit light sample. It also captures the 16 bits the master shifts in on MOSI.

## Interface
Parameters:
- FRAME_BITS, 16, SCLK cycles per complete frame
- LEAD_ZEROS, 3, zero bits transmitted before the 8 data bits; trailing bits are zero

Ports:
- clck_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- sclk_i  in  1  SPI clock from master (CPOL=0, CPHA=0), asynchronous to clck_i
- cs_i  in  1  chip select from master, active-low
- mosi_i  in  1  master-to-responder data
- miso_o  out  1  responder-to-master data
- sample_i  in  8  next light sample
- sample_wr_i  in  1  one-cycle strobe; loads sample_i into the holding register
- rx_data_o  out  16  last complete MOSI frame, MSB first
- frame_done_o  out  1  one-cycle pulse on completion of a full frame
- busy_o  out  1  high while a frame is in progress
- stale_o  out  1  high when the frame in flight carries a sample already sent

## Operation
- sclk_i, cs_i and mosi_i each pass through a 2-FF synchronizer into clck_i. Edge detectors on the synchronized sclk and cs produce one-cycle rise/fall strobes.
- Holding register hold_q[7:0] is written by sample_wr_i in any state. A fresh flag is set on each write.
- FSM states:
  - IDLE: miso_o=0, busy_o=0. On a cs fall strobe: shift_q = {LEAD_ZEROS zeros, hold_q, zeros} (FRAME_BITS wide); stale_o = ~fresh; fresh cleared; bit_cnt=0; go to SHIFT.
  - SHIFT: miso_o = shift_q[MSB]. On an sclk rise: mosi captured into rx_shift_q (shift left) and bit_cnt++. On an sclk fall: shift_q shifts left, zero-fill. When bit_cnt reaches FRAME_BITS, go to HOLD.
  - HOLD: miso_o=0. Further SCLK edges are ignored and do not affect rx. On a cs rise: rx_data_o <= rx_shift_q, pulse frame_done_o, go to IDLE.
- A cs rise in SHIFT aborts the frame. The FSM returns to IDLE with no frame_done_o pulse and rx_data_o unchanged. The sample counts as consumed, so fresh stays cleared.
- When sample_wr_i and the cs fall strobe occur in the same cycle, the frame loads the old hold_q. The new value lands in hold_q and sets fresh.
- Reset values: miso_o=0, rx_data_o=16'h0000, frame_done_o=0, busy_o=0, stale_o=0, hold_q=8'h00, fresh=0, state IDLE.
- Reset asserted mid-frame returns everything to reset values immediately. The first cs fall after release starts a new frame; a CS already low at release does not start one.

## Timing
- Synchronizer plus edge detect adds 3 clck_i cycles from a pin edge to its strobe.
- miso_o updates 1 cycle after the strobe, so 4 clck_i cycles after the falling sclk/cs pin edge.
- Requirement: the SCLK half-period must be at least 6 clck_i cycles, so MISO is stable before the master's rising-edge sample.
- The first data bit (bit FRAME_BITS-1) is on miso_o 4 cycles after the cs fall. It must precede the first SCLK rise by at least 2 cycles.
- frame_done_o fires 4 cycles after the cs pin rise. rx_data_o is valid in the same cycle.
- busy_o is high from the cycle after the cs fall strobe until the cycle of the cs rise strobe.

## Configuration
- ALS_RESP_LFSR_EN defined:
  - sample source becomes an internal 8-bit Galois LFSR (taps x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset), advanced once per completed frame
  - sample_i and sample_wr_i are ignored; stale_o is tied 0
- Not defined: sample_i/sample_wr_i drive hold_q as described under Operation.

## Test plan
- hold_q=8'hB7, full 16-clock frame -> master reads 16'b000_10110111_00000. frame_done_o pulses once. stale_o=0.
- Master shifts 16'hC3A5 on MOSI -> rx_data_o=16'hC3A5 at frame_done_o.
- Two frames with no sample_wr_i between them -> second frame returns the same data with stale_o=1.
- CS raised after 7 SCLKs -> no frame_done_o, rx_data_o unchanged. The next full frame is correct from bit 15.
- sample_wr_i with 8'h3C in the cs-fall strobe cycle -> frame sends the old value; the following frame sends 8'h3C.
- rst_i pulsed low at SCLK 9 -> all outputs at reset values. A subsequent frame returns data 8'h00 with stale_o=1.
